led_fade_sequencer: RTL

- Drives the 4-bit duty_cycle input of pwm_top so the LED dimmer can fade without software stepping each level.
- Accepts one command at a time over a valid/ready handshake:
  - SET: jump to a level.
  - RAMP: step toward a level at a programmable rate.
  - BREATHE: oscillate between 0 and a level.
  - STOP: freeze the current level.
- Sits between the control/register logic and pwm_top.

---
 rtl/led_dim_pkg.sv | 15 +
 rtl/led_fade_sequencer_step_timer.sv | 25 ++
 rtl/led_fade_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/led_dim_pkg.sv
// led_dim_pkg: shared widths, command encodings and sequencer states for the LED dimmer
package led_dim_pkg;
  localparam int DUTY_W = 4;
  localparam int STEP_W = 16;
  localparam logic [1:0] MODE_SET     = 2'b00;
  localparam logic [1:0] MODE_RAMP    = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_STOP    = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_BREATHE_UP,
    ST_BREATHE_DN
  } state_t;
endpackage

// File: rtl/led_fade_sequencer_step_timer.sv
// step_timer: reloadable down-counter that ticks while at zero and reloads itself
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;
  logic [W-1:0] rel;
  assign tick = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rel <= '0;
    end else if (load) begin
      cnt <= load_val;
      rel <= load_val;
    end else begin
      cnt <= tick ? rel : cnt - 1'b1;
    end
  end
endmodule

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: SET/RAMP/BREATHE/STOP command engine driving the pwm_top duty level
module led_fade_sequencer #(
  parameter int DUTY_W = led_dim_pkg::DUTY_W,
  parameter int STEP_W = led_dim_pkg::STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done
);
  import led_dim_pkg::*;
  state_t            state;
  logic [DUTY_W-1:0] tgt;
  logic [DUTY_W-1:0] up;
  logic [DUTY_W-1:0] dn;
  logic [STEP_W-1:0] load_val;
  logic              accept;
  logic              load;
  logic              tick;
  assign accept   = cmd_valid & cmd_ready;
  assign load     = accept & (cmd_mode == MODE_RAMP | cmd_mode == MODE_BREATHE);
  assign load_val = (cmd_step == '0) ? '0 : cmd_step - 1'b1;
  assign up       = duty_cycle + 1'b1;
  assign dn       = duty_cycle - 1'b1;
  step_timer #(.W(STEP_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .tick    (tick)
  );
  // An accept always takes priority, so a coincident tick is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      duty_cycle <= '0;
      tgt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tgt <= cmd_target;
        case (cmd_mode)
          MODE_SET: begin
            duty_cycle <= cmd_target;
            done       <= 1'b1;
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
          end
          MODE_RAMP: begin
            done      <= cmd_target == duty_cycle;
            state     <= (cmd_target == duty_cycle) ? ST_IDLE : ST_RAMP;
            busy      <= cmd_target != duty_cycle;
            cmd_ready <= cmd_target == duty_cycle;
          end
          MODE_BREATHE: begin
            duty_cycle <= (cmd_target == '0) ? '0 : duty_cycle;
            done       <= cmd_target == '0;
            state      <= (cmd_target == '0) ? ST_IDLE :
                          (duty_cycle >= cmd_target) ? ST_BREATHE_DN : ST_BREATHE_UP;
            busy       <= cmd_target != '0;
            cmd_ready  <= 1'b1;
          end
          default: begin
            done      <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        endcase
      end else begin
        case (state)
          ST_RAMP: begin
            if (duty_cycle == tgt) begin
              done      <= 1'b1;
              state     <= ST_IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else if (tick) begin
              duty_cycle <= (duty_cycle < tgt) ? up : dn;
            end
          end
          ST_BREATHE_UP: begin
            if (tick) begin
              duty_cycle <= up;
              state      <= (up == tgt) ? ST_BREATHE_DN : ST_BREATHE_UP;
            end
          end
          ST_BREATHE_DN: begin
            if (tick) begin
              duty_cycle <= dn;
              state      <= (dn == '0) ? ST_BREATHE_UP : ST_BREATHE_DN;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
